// File: rtl/pixel_frame_writer.sv
// Buffers a valid/ready pixel stream in a small FIFO and writes one frame
// sequentially into memory. Optional frame checksum: define PIXEL_CHECKSUM_EN.
module pixel_frame_writer #(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 384,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_pixel_i,
   output logic              in_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic [15:0]       checksum_o
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] wr_q, wr_d;
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_s, empty_s, in_ready_s, push_s, pop_s, clr_s;
   logic [7:0]       head_s;

   // Full/empty come from the registered occupancy, so a same-cycle pop never frees a slot
   assign full_s     = (count_q == DEPTH_C);
   assign empty_s    = (count_q == '0);
   assign in_ready_s = (state_q == ST_RUN) & ~full_s;
   assign push_s     = in_valid_i & in_ready_s;
   assign pop_s      = ~empty_s & mem_ready_i;
   assign head_s     = fifo_mem_q[rptr_q];

   assign in_ready_o   = in_ready_s;
   assign mem_we_o     = ~empty_s;
   assign mem_wdata_o  = empty_s ? 8'h00 : head_s;
   assign mem_addr_o   = wr_q[ADDR_W-1:0];
   assign busy_o       = (state_q == ST_RUN) | (state_q == ST_DRAIN);
   assign frame_done_o = (state_q == ST_DONE);

   // FIFO pointer and occupancy next-state
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_s) begin
         wptr_d = wptr_q + PTR_W'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = rptr_q + PTR_W'(1);
      end else begin
         rptr_d = rptr_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + (PTR_W + 1)'(1);
      end else if (pop_s && !push_s) begin
         count_d = count_q - (PTR_W + 1)'(1);
      end else begin
         count_d = count_q;
      end
   end

   // FIFO storage; contents are only observed through the occupancy-gated head
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_q[wptr_q] <= in_pixel_i;
      end
   end

   // Frame sequencing and accept/write counters
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      wr_d    = pop_s ? (wr_q + CNT_W'(1)) : wr_q;
      clr_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               acc_d   = '0;
               wr_d    = '0;
               clr_s   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (push_s) begin
               acc_d = acc_q + CNT_W'(1);
               if ((acc_q + CNT_W'(1)) == TOTAL_C) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (pop_s && ((wr_q + CNT_W'(1)) == TOTAL_C)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         wr_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         wr_q    <= wr_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

`ifdef PIXEL_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   // Wrap-around sum of every pixel actually written to memory
   always_comb begin
      csum_d = csum_q;
      if (clr_s) begin
         csum_d = 16'h0000;
      end else if (pop_s) begin
         csum_d = csum_q + {8'h00, head_s};
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= 16'h0000;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum_o = csum_q;
`else
   logic unused_clr_s;
   assign unused_clr_s = clr_s;
   assign checksum_o   = 16'h0000;
`endif

endmodule
